// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MUL   = 2'b00,
        MDU_MULHU = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_REMU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

    function automatic logic is_div(mdu_op_e o);
        return (o == MDU_DIVU) || (o == MDU_REMU);
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide: one shift-add or restoring shift-subtract step per clock.
// acc_q holds the product high half or the remainder; lo_q holds multiplier/product low or quotient.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    localparam int unsigned CntW = $clog2(WIDTH);

    state_e           state_q, state_d;
    mdu_op_e          op_q, op_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] step_acc;
    logic [WIDTH-1:0] step_lo;
    mdu_op_e          op_in;

    assign op_in = mdu_op_e'(op);

    // One iteration of the selected algorithm on the current registers.
    always_comb begin
        sum      = {1'b0, acc_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        shifted  = {acc_q, lo_q[WIDTH-1]};
        diff     = shifted - {1'b0, m_q};
        step_acc = acc_q;
        step_lo  = lo_q;
        if (is_div(op_q)) begin
            if (!diff[WIDTH]) begin
                step_acc = diff[WIDTH-1:0];
                step_lo  = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_acc = shifted[WIDTH-1:0];
                step_lo  = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_acc = sum[WIDTH:1];
            step_lo  = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        m_d      = m_q;
        lo_d     = lo_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        dbz_d    = dbz_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    op_d  = op_in;
                    acc_d = '0;
                    cnt_d = '0;
                    if (is_div(op_in)) begin
                        m_d  = operand_b;
                        lo_d = operand_a;
                    end else begin
                        m_d  = operand_a;
                        lo_d = operand_b;
                    end
                    if (is_div(op_in) && (operand_b == '0)) begin
                        result_d = (op_in == MDU_DIVU) ? '1 : operand_a;
                        dbz_d    = 1'b1;
                        state_d  = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = step_acc;
                lo_d  = step_lo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    result_d = ((op_q == MDU_MUL) || (op_q == MDU_DIVU)) ? step_lo : step_acc;
                    dbz_d    = 1'b0;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= MDU_MUL;
            m_q      <= '0;
            lo_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            m_q      <= m_d;
            lo_q     <= lo_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
        end
    end

    assign ready       = (state_q == IDLE) || (state_q == DONE);
    assign busy        = (state_q == CALC);
    assign done        = (state_q == DONE);
    assign result      = result_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed results, latency and control behaviour.
module tb_mul_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        div_by_zero;

    int n_checks = 0;
    int n_errors = 0;
    int lat;

    localparam logic [1:0] OpMul   = 2'b00;
    localparam logic [1:0] OpMulhu = 2'b01;
    localparam logic [1:0] OpDivu  = 2'b10;
    localparam logic [1:0] OpRemu  = 2'b11;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive a request now (callers sit #1 after an edge) and let the next edge sample it.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op        = o;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges after the start edge until done is seen; bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_r, input logic exp_dbz,
                          input int exp_lat);
        int n;
        launch(o, a, b);
        wait_done(n);
        chk({tag, " latency"}, 32'(n), 32'(exp_lat));
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " result"}, result, exp_r);
        chk({tag, " dbz"}, 32'(div_by_zero), 32'(exp_dbz));
        @(posedge clk);
        #1;
        chk({tag, " done pulse ends"}, 32'(done), 32'd0);
        chk({tag, " result held"}, result, exp_r);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        op        = OpMul;
        operand_a = '0;
        operand_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ready", 32'(ready), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("mul 7*6", OpMul, 32'd7, 32'd6, 32'd42, 1'b0, 32);
        run_op("mul ffffffff*2", OpMul, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, 32);
        run_op("mulhu ffffffff*2", OpMulhu, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 1'b0, 32);
        run_op("mulhu ffffffff^2", OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0,
               32);
        run_op("divu 100/7", OpDivu, 32'd100, 32'd7, 32'd14, 1'b0, 32);
        run_op("remu 100/7", OpRemu, 32'd100, 32'd7, 32'd2, 1'b0, 32);
        run_op("divu 5/9", OpDivu, 32'd5, 32'd9, 32'd0, 1'b0, 32);
        run_op("remu 5/9", OpRemu, 32'd5, 32'd9, 32'd5, 1'b0, 32);
        // Divide by zero completes in the cycle right after the start edge.
        run_op("divu 5/0", OpDivu, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 0);
        run_op("remu 5/0", OpRemu, 32'd5, 32'd0, 32'd5, 1'b1, 0);
        run_op("mul clears dbz", OpMul, 32'd3, 32'd5, 32'd15, 1'b0, 32);

        // A start during CALC must be ignored.
        launch(OpMul, 32'd3, 32'd4);
        repeat (9) @(posedge clk);
        #1;
        chk("busy mid calc", 32'(busy), 32'd1);
        chk("ready mid calc", 32'(ready), 32'd0);
        launch(OpDivu, 32'd8, 32'd2);
        operand_a = 32'd0;
        operand_b = 32'd0;
        wait_done(lat);
        chk("ignored start latency", 32'(lat), 32'd22);
        chk("ignored start result", result, 32'd12);
        // Back-to-back request issued in the done cycle.
        launch(OpMul, 32'd5, 32'd5);
        chk("b2b busy", 32'(busy), 32'd1);
        wait_done(lat);
        chk("b2b latency", 32'(lat), 32'd32);
        chk("b2b result", result, 32'd25);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-operation.
        launch(OpMul, 32'd9, 32'd9);
        repeat (14) @(posedge clk);
        #1;
        chk("busy before abort", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort ready", 32'(ready), 32'd1);
        chk("abort result", result, 32'd0);
        chk("abort done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) lat++;
        end
        chk("no done after abort", 32'(lat), 32'd0);
        run_op("mul 2*3 after reset", OpMul, 32'd2, 32'd3, 32'd6, 1'b0, 32);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
